// File: rtl/ifu_fetch_buf.sv
// ----------------------------------------------------------------------------
// ifu_fetch_buf
//   Instruction fetch stage sitting in front of decode. It owns the fetch PC,
//   issues word reads to instruction memory, tracks the PC and epoch of every
//   accepted request in an in-flight tag queue, and buffers returning
//   {pc, instr, err} triples in a small registered FIFO for decode.
//
//   A redirect from execute flushes the FIFO, toggles the epoch and restarts
//   fetch at the new target. Requests already in flight are not cancelled.
//   Their responses still drain and return credit, but they carry the old
//   epoch and are dropped.
//
// Parameters
//   PC_WIDTH         width of fetch / redirect PCs and imem address
//   RESET_PC         first fetch address after reset
//   FIFO_DEPTH       output buffer entries (power of two, >= 2)
//   MAX_OUTSTANDING  max accepted-but-unanswered imem requests (>= 1)
//
// Ports
//   clk_i, rst_n_i       clock (rising edge) / async active-low reset
//   redirect_i           flush and restart fetch at redirect_pc_i
//   redirect_pc_i        new fetch PC, low two bits ignored
//   imem_req_valid_o     fetch request valid
//   imem_req_ready_i     imem accepts the request this cycle
//   imem_req_addr_o      word-aligned fetch address (current fetch PC)
//   imem_rsp_valid_i     response valid, returned in request order
//   imem_rsp_data_i      fetched instruction word
//   imem_rsp_err_i       access fault for this response
//   inst_valid_o         buffered instruction available to decode
//   inst_ready_i         decode consumes the head entry
//   inst_o               head instruction
//   inst_pc_o            PC of the head instruction
//   inst_err_o           head entry carries an access fault
//   perf_stall_cnt_o     cycles decode was ready but starved (optional)
//
// Configuration macro
//   IFU_PERF_CNT_EN  when defined, adds perf_stall_cnt_o and its saturating
//                    counter. When undefined the port and counter are absent.
// ----------------------------------------------------------------------------

// Protocol checker: flags an imem response that arrives while no request is
// outstanding.
module ifu_fetch_buf_chk #(
  parameter int OST_W = 2
) (
  input logic             clk_i,
  input logic             rst_n_i,
  input logic             rsp_valid_i,
  input logic [OST_W-1:0] outstanding_i
);

  a_rsp_needs_req: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    rsp_valid_i |-> (outstanding_i != {OST_W{1'b0}}));

endmodule

module ifu_fetch_buf #(
  parameter int                  PC_WIDTH        = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = 32'h8000_0000,
  parameter int                  FIFO_DEPTH      = 2,
  parameter int                  MAX_OUTSTANDING = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                imem_req_valid_o,
  input  logic                imem_req_ready_i,
  output logic [PC_WIDTH-1:0] imem_req_addr_o,
  input  logic                imem_rsp_valid_i,
  input  logic [31:0]         imem_rsp_data_i,
  input  logic                imem_rsp_err_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [31:0]         inst_o,
  output logic [PC_WIDTH-1:0] inst_pc_o,
  output logic                inst_err_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cnt_o
`endif
);

  localparam int FPW   = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TPW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [PC_WIDTH-1:0] PC_LOW_MASK = {{(PC_WIDTH-2){1'b0}}, 2'b11};
  localparam logic [PC_WIDTH-1:0] PC_STEP     = {{(PC_WIDTH-3){1'b0}}, 3'b100};

  // Ring-pointer advance for the in-flight tag queue. Its depth need not be a
  // power of two, so the wrap is explicit.
  function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] ptr);
    if (ptr == TPW'(MAX_OUTSTANDING - 1)) begin
      return {TPW{1'b0}};
    end else begin
      return ptr + TPW'(1'b1);
    end
  endfunction

  // Architectural state
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                epoch_q, epoch_d;
  logic [OST_W-1:0]    ost_q, ost_d;

  // In-flight tag queue: {addr, epoch} per accepted request
  logic [PC_WIDTH-1:0] tag_addr_q  [MAX_OUTSTANDING];
  logic                tag_epoch_q [MAX_OUTSTANDING];
  logic [TPW-1:0]      tag_wr_q, tag_wr_d;
  logic [TPW-1:0]      tag_rd_q, tag_rd_d;

  // Output FIFO
  logic [PC_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]         fifo_instr_q [FIFO_DEPTH];
  logic                fifo_err_q   [FIFO_DEPTH];
  logic [FPW-1:0]      fifo_wr_q, fifo_wr_d;
  logic [FPW-1:0]      fifo_rd_q, fifo_rd_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

  // Handshake / event strobes
  logic                credit_ok_s;
  logic                req_valid_s;
  logic                req_fire_s;
  logic                rsp_fire_s;
  logic [PC_WIDTH-1:0] rsp_addr_s;
  logic                rsp_epoch_s;
  logic                push_s;
  logic                inst_valid_s;
  logic                pop_s;

  // Event decode. The credit rule counts both in-flight requests and
  // buffered entries against the FIFO depth, so every response is
  // guaranteed a free slot and the FIFO never needs to backpressure imem.
  // Gating with rst_n_i keeps the request valid low while reset is held.
  always_comb begin
    credit_ok_s  = (32'(ost_q) + 32'(fifo_cnt_q)) < 32'(FIFO_DEPTH);
    req_valid_s  = rst_n_i && !redirect_i &&
                   (32'(ost_q) < 32'(MAX_OUTSTANDING)) && credit_ok_s;
    req_fire_s   = req_valid_s && imem_req_ready_i;
    rsp_fire_s   = imem_rsp_valid_i;
    rsp_addr_s   = tag_addr_q[tag_rd_q];
    rsp_epoch_s  = tag_epoch_q[tag_rd_q];
    // Responses tagged with an older epoch, or landing in a redirect cycle,
    // belong to the discarded path.
    push_s       = rsp_fire_s && (rsp_epoch_s == epoch_q) && !redirect_i;
    inst_valid_s = (fifo_cnt_q != {CNT_W{1'b0}});
    pop_s        = inst_valid_s && inst_ready_i && !redirect_i;
  end

  // Next-state logic for fetch PC, epoch, credit counter and queue pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    ost_d      = ost_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~PC_LOW_MASK;
      epoch_d    = ~epoch_q;
    end else if (req_fire_s) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      epoch_d    = epoch_q;
    end else begin
      fetch_pc_d = fetch_pc_q;
      epoch_d    = epoch_q;
    end

    // Outstanding is never cleared by redirect. Stale responses still
    // return their credit as they drain.
    case ({req_fire_s, rsp_fire_s})
      2'b10:   ost_d = ost_q + OST_W'(1'b1);
      2'b01:   ost_d = ost_q - OST_W'(1'b1);
      default: ost_d = ost_q;
    endcase

    if (req_fire_s) begin
      tag_wr_d = tag_next(tag_wr_q);
    end else begin
      tag_wr_d = tag_wr_q;
    end

    if (rsp_fire_s) begin
      tag_rd_d = tag_next(tag_rd_q);
    end else begin
      tag_rd_d = tag_rd_q;
    end

    if (redirect_i) begin
      fifo_wr_d  = {FPW{1'b0}};
      fifo_rd_d  = {FPW{1'b0}};
      fifo_cnt_d = {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          fifo_wr_d  = fifo_wr_q + FPW'(1'b1);
          fifo_cnt_d = fifo_cnt_q + CNT_W'(1'b1);
        end
        2'b01: begin
          fifo_rd_d  = fifo_rd_q + FPW'(1'b1);
          fifo_cnt_d = fifo_cnt_q - CNT_W'(1'b1);
        end
        2'b11: begin
          fifo_wr_d  = fifo_wr_q + FPW'(1'b1);
          fifo_rd_d  = fifo_rd_q + FPW'(1'b1);
        end
        default: begin
          fifo_wr_d  = fifo_wr_q;
          fifo_rd_d  = fifo_rd_q;
          fifo_cnt_d = fifo_cnt_q;
        end
      endcase
    end
  end

  // Control registers: fetch PC, epoch, credit counter, queue pointers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q <= RESET_PC;
      epoch_q    <= 1'b0;
      ost_q      <= {OST_W{1'b0}};
      tag_wr_q   <= {TPW{1'b0}};
      tag_rd_q   <= {TPW{1'b0}};
      fifo_wr_q  <= {FPW{1'b0}};
      fifo_rd_q  <= {FPW{1'b0}};
      fifo_cnt_q <= {CNT_W{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
      ost_q      <= ost_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Queue storage. It is cleared on reset so the head outputs read zero
  // while reset is held.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= {PC_WIDTH{1'b0}};
        fifo_instr_q[i] <= 32'h0000_0000;
        fifo_err_q[i]   <= 1'b0;
      end
      for (int j = 0; j < MAX_OUTSTANDING; j++) begin
        tag_addr_q[j]  <= {PC_WIDTH{1'b0}};
        tag_epoch_q[j] <= 1'b0;
      end
    end else begin
      if (push_s) begin
        fifo_pc_q[fifo_wr_q]    <= rsp_addr_s;
        fifo_instr_q[fifo_wr_q] <= imem_rsp_data_i;
        fifo_err_q[fifo_wr_q]   <= imem_rsp_err_i;
      end
      if (req_fire_s) begin
        tag_addr_q[tag_wr_q]  <= fetch_pc_q;
        tag_epoch_q[tag_wr_q] <= epoch_q;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Starved-decode counter: saturates and survives redirects.
  always_comb begin
    if (inst_ready_i && !inst_valid_s && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end else begin
      perf_cnt_d = perf_cnt_q;
    end
  end

  // Starved-decode counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_cnt_q <= 32'h0000_0000;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_stall_cnt_o = perf_cnt_q;
`endif

  assign imem_req_valid_o = req_valid_s;
  assign imem_req_addr_o  = fetch_pc_q;
  assign inst_valid_o     = inst_valid_s;
  assign inst_o           = fifo_instr_q[fifo_rd_q];
  assign inst_pc_o        = fifo_pc_q[fifo_rd_q];
  assign inst_err_o       = fifo_err_q[fifo_rd_q];

  ifu_fetch_buf_chk #(
    .OST_W (OST_W)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .rsp_valid_i   (imem_rsp_valid_i),
    .outstanding_i (ost_q)
  );

endmodule
